// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master data path.
//   spi_state_t   : transfer FSM states
//   MODE0..MODE3  : SPI mode encodings, {cpol, cpha}
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } spi_state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_edge_det.sv
// SCLK edge classifier for the SPI master shifter.
// sclk arrives as a clk-synchronous register from the clock generator, so a
// single delay stage is enough to see its transitions.
//   clk, rst     : system clock, synchronous active-high reset
//   sclk         : serial clock from the generator
//   cpol_q       : latched clock idle level of the current transfer
//   en           : high while chip select is asserted
//   lead_pulse   : sclk just left its idle level
//   trail_pulse  : sclk just returned to its idle level
module spi_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cpol_q,
    input  logic en,
    output logic lead_pulse,
    output logic trail_pulse
);

    logic sclk_d;
    logic toggled;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge value of its inputs, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d <= 1'b0;
        end else begin
            sclk_d <= sclk;
        end
    end

    // Edge direction is judged from the level sclk had before the edge.
    assign toggled     = en && (sclk != sclk_d);
    assign lead_pulse  = toggled && (sclk_d == cpol_q);
    assign trail_pulse = toggled && (sclk_d != cpol_q);

endmodule

// File: rtl/spi_master_shifter.sv
// SPI master data path: serialises one DATA_W-bit word on mosi and
// deserialises miso into rx_data, following the latched CPOL/CPHA mode.
// Runs alongside an external SCLK generator that it gates through cs_n.
//   clk, rst           : system clock, synchronous active-high reset
//   start              : one-cycle request, accepted only when idle
//   tx_data, cpol, cpha: transfer word and mode, captured on accepted start
//   sclk, miso         : serial clock from the generator, serial data in
//   cs_n, mosi         : chip select (also generator enable), serial data out
//   rx_data            : last received word, updated with the done pulse
//   busy, done         : transfer in progress, one-cycle completion pulse
module spi_master_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              miso,
    output logic              cs_n,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

    spi_state_t        state, state_next;
    logic [DATA_W-1:0] tx_sh, tx_sh_next;
    logic [DATA_W-1:0] rx_sh, rx_sh_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic              cpol_q, cpha_q;
    logic              active;
    logic              lead, trail;
    logic              sample, shift;
    logic              accept;

    // Moves the word one position in the configured direction, inserting b
    // at the end that is filled last.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                   input logic              b);
        return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    spi_edge_det u_edge_det (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cpol_q     (cpol_q),
        .en         (active),
        .lead_pulse (lead),
        .trail_pulse(trail)
    );

    // Chip select stays low through TAIL so the last half-period of sclk is
    // still inside the frame; status outputs decode straight from state.
    assign active = (state == XFER) || (state == TAIL);
    assign cs_n   = !active;
    assign busy   = active;
    assign done   = (state == DONE);
    assign accept = (state == IDLE) && start;

    // CPHA=1 launches on leading edges, but the first bit is already on mosi
    // from the start edge, so the leading edge with bit_cnt==0 only
    // re-presents it.
    assign sample = (state == XFER) && (cpha_q ? trail : lead);
    assign shift  = (state == XFER) &&
                    (cpha_q ? (lead && (bit_cnt != '0)) : trail);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = XFER;
            XFER: begin
                // CPHA=0 still owes one trailing edge to park sclk at cpol.
                if (sample && (bit_cnt == LAST_BIT)) begin
                    state_next = cpha_q ? DONE : TAIL;
                end
            end
            TAIL: if (trail) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_sh_next = tx_sh;
        rx_sh_next = rx_sh;
        if (shift)  tx_sh_next = shift_in(tx_sh, 1'b0);
        if (sample) rx_sh_next = shift_in(rx_sh, miso);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            bit_cnt <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            mosi    <= 1'b0;
        end else if (accept) begin
            tx_sh   <= tx_data;
            rx_sh   <= '0;
            bit_cnt <= '0;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            mosi    <= first_bit(tx_data);
        end else begin
            tx_sh <= tx_sh_next;
            rx_sh <= rx_sh_next;
            if (shift) mosi <= first_bit(tx_sh_next);
            if (sample && (bit_cnt != FULL_CNT)) bit_cnt <= bit_cnt + CNT_W'(1);
            // The final CPHA=1 sample lands on this same edge, so the word is
            // taken from the next-value path rather than the register.
            if ((state_next == DONE) && (state != DONE)) begin
                rx_data <= rx_sh_next;
                mosi    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: two instances (MSB-first and LSB-first), each
// with a behavioural SCLK generator, a slave/loopback data source and a
// negedge monitor that counts sclk edges, done pulses and mosi bit errors.
module tb_spi_master_shifter;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_m = 1'b0, start_l = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, loop = 1'b1;
    logic [7:0] tx_data = 8'h00, slave_word = 8'h00;
    int         div = 0;
    bit         mon_sel = 1'b0;

    logic       sclk_m, sclk_l, miso_m, miso_l;
    logic       cs_n_m, cs_n_l, mosi_m, mosi_l;
    logic       busy_m, busy_l, done_m, done_l;
    logic [7:0] rx_m, rx_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_master_shifter #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .tx_data(tx_data),
        .cpol(cpol), .cpha(cpha), .sclk(sclk_m), .miso(miso_m),
        .cs_n(cs_n_m), .mosi(mosi_m), .rx_data(rx_m), .busy(busy_m), .done(done_m)
    );

    spi_master_shifter #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .start(start_l), .tx_data(tx_data),
        .cpol(cpol), .cpha(cpha), .sclk(sclk_l), .miso(miso_l),
        .cs_n(cs_n_l), .mosi(mosi_l), .rx_data(rx_l), .busy(busy_l), .done(done_l)
    );

    // Clock generators: idle at cpol while cs_n is high, forced to 0 by
    // reset, toggle every (2 << div) clk while cs_n is low.
    int gcnt_m, gcnt_l;
    always @(posedge clk) begin
        if (rst) begin
            sclk_m <= 1'b0; gcnt_m <= 0;
        end else if (cs_n_m) begin
            sclk_m <= cpol; gcnt_m <= 0;
        end else if (gcnt_m == (2 << div) - 1) begin
            sclk_m <= ~sclk_m; gcnt_m <= 0;
        end else begin
            gcnt_m <= gcnt_m + 1;
        end
    end
    always @(posedge clk) begin
        if (rst) begin
            sclk_l <= 1'b0; gcnt_l <= 0;
        end else if (cs_n_l) begin
            sclk_l <= cpol; gcnt_l <= 0;
        end else if (gcnt_l == (2 << div) - 1) begin
            sclk_l <= ~sclk_l; gcnt_l <= 0;
        end else begin
            gcnt_l <= gcnt_l + 1;
        end
    end

    // Monitor, muxed onto the instance under test.
    logic       m_sclk, m_cs_n, m_mosi, m_busy, m_done, m_start;
    logic [7:0] m_rx;
    assign m_sclk  = mon_sel ? sclk_l  : sclk_m;
    assign m_cs_n  = mon_sel ? cs_n_l  : cs_n_m;
    assign m_mosi  = mon_sel ? mosi_l  : mosi_m;
    assign m_busy  = mon_sel ? busy_l  : busy_m;
    assign m_done  = mon_sel ? done_l  : done_m;
    assign m_start = mon_sel ? start_l : start_m;
    assign m_rx    = mon_sel ? rx_l    : rx_m;

    logic       sclk_p = 1'b0, cs_p = 1'b1, busy_p = 1'b0, smp_p = 1'b0;
    logic [7:0] mon_tx = 8'h00;
    logic [2:0] slv_idx = 3'd0;
    int mon_edges = 0, mon_smps = 0, mon_dones = 0, mon_mosi_err = 0;
    int mon_cpol_err = 0, mon_busy_err = 0, gap_run = 0, last_gap = 0;
    logic smp_now;

    assign smp_now = !m_cs_n && (m_sclk != sclk_p) && ((sclk_p == cpol) ^ cpha);

    // Slave advances to its next bit one clk after the master has sampled.
    assign miso_m = loop ? mosi_m : slave_word[3'd7 - slv_idx];
    assign miso_l = mosi_l;

    function automatic logic exp_bit(input logic [7:0] w, input int n, input bit lsb);
        if (n < 0 || n > 7) return 1'b0;
        return lsb ? w[n] : w[7-n];
    endfunction

    always @(negedge clk) begin
        sclk_p <= m_sclk;
        cs_p   <= m_cs_n;
        busy_p <= m_busy;
        smp_p  <= smp_now;
        if (m_cs_n) slv_idx <= 3'd0;
        else if (smp_p) slv_idx <= slv_idx + 3'd1;
        if (m_cs_n) gap_run <= gap_run + 1;
        else begin
            if (cs_p) last_gap <= gap_run;
            gap_run <= 0;
        end
        if (m_start && m_cs_n && !m_done && !rst) begin
            mon_edges <= 0; mon_smps <= 0; mon_dones <= 0;
            mon_mosi_err <= 0; mon_cpol_err <= 0; mon_busy_err <= 0;
            mon_tx <= tx_data;
        end else begin
            if (!m_cs_n && (m_sclk != sclk_p)) mon_edges <= mon_edges + 1;
            if (smp_now) begin
                mon_smps <= mon_smps + 1;
                if (m_mosi !== exp_bit(mon_tx, mon_smps, mon_sel))
                    mon_mosi_err <= mon_mosi_err + 1;
            end
            if (m_done) mon_dones <= mon_dones + 1;
            if (m_done && (m_busy || !busy_p)) mon_busy_err <= mon_busy_err + 1;
            if (m_cs_n && !cs_p && !rst && (m_sclk !== cpol)) mon_cpol_err <= mon_cpol_err + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] mode, input logic lp, input logic [7:0] slv);
        tick();
        cpol = mode[1];
        cpha = mode[0];
        loop = lp;
        slave_word = slv;
        repeat (3) tick();
    endtask

    task automatic begin_xfer(input bit sel, input logic [7:0] tx);
        tick();
        tx_data = tx;
        if (sel) start_l = 1'b1; else start_m = 1'b1;
        tick();
        start_m = 1'b0;
        start_l = 1'b0;
    endtask

    // Waits for done, checks the completed word and the monitor totals.
    // With chain set, the next start is issued in the cycle after done.
    task automatic finish_xfer(input string tag, input logic [7:0] exp_rx, input int budget,
                               input bit chain, input logic [7:0] next_tx);
        int n = 0;
        @(negedge clk);
        while (!m_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done within budget"}, 32'(n < budget), 32'd1);
        check({tag, " rx_data"}, 32'(m_rx), 32'(exp_rx));
        check({tag, " busy low in done cycle"}, 32'(m_busy), 32'd0);
        check({tag, " cs_n high in done cycle"}, 32'(m_cs_n), 32'd1);
        check({tag, " mosi low in done cycle"}, 32'(m_mosi), 32'd0);
        if (chain) begin
            tick();
            tx_data = next_tx;
            start_m = 1'b1;
        end
        @(negedge clk);
        check({tag, " done is one cycle"}, 32'(m_done), 32'd0);
        check({tag, " sclk edges"}, 32'(mon_edges), 32'd16);
        check({tag, " sample edges"}, 32'(mon_smps), 32'd8);
        check({tag, " done pulses"}, 32'(mon_dones), 32'd1);
        check({tag, " mosi errors"}, 32'(mon_mosi_err), 32'd0);
        check({tag, " sclk idle at cs_n rise"}, 32'(mon_cpol_err), 32'd0);
        check({tag, " busy/done timing"}, 32'(mon_busy_err), 32'd0);
        if (chain) begin
            tick();
            start_m = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] tx;
        logic       lp;
        logic [7:0] slv;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        vecs[0] = '{MODE0, 8'hA5, 1'b1, 8'h00, 8'hA5};
        vecs[1] = '{MODE1, 8'h3C, 1'b0, 8'hC3, 8'hC3};
        vecs[2] = '{MODE2, 8'h3C, 1'b0, 8'hC3, 8'hC3};
        vecs[3] = '{MODE3, 8'h3C, 1'b0, 8'hC3, 8'hC3};
        vecs[4] = '{MODE0, 8'h3C, 1'b0, 8'h5E, 8'h5E};
        vecs[5] = '{MODE3, 8'h81, 1'b1, 8'h00, 8'h81};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset cs_n", 32'(cs_n_m), 32'd1);
        check("reset mosi", 32'(mosi_m), 32'd0);
        check("reset rx_data", 32'(rx_m), 32'd0);
        check("reset busy", 32'(busy_m), 32'd0);
        check("reset done", 32'(done_m), 32'd0);

        // T1/T2: table of single-word transfers on the MSB-first instance
        for (int i = 0; i < 6; i++) begin
            set_mode(vecs[i].mode, vecs[i].lp, vecs[i].slv);
            begin_xfer(1'b0, vecs[i].tx);
            @(negedge clk);
            check($sformatf("vec%0d busy after start", i), 32'(busy_m), 32'd1);
            check($sformatf("vec%0d cs_n after start", i), 32'(cs_n_m), 32'd0);
            finish_xfer($sformatf("vec%0d", i), vecs[i].exp_rx, 200, 1'b0, 8'h00);
        end

        // T5: reset after the 4th sample edge, then a clean transfer
        set_mode(MODE0, 1'b1, 8'h00);
        begin_xfer(1'b0, 8'h96);
        n = 0;
        while (mon_smps < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("T5 reached 4th sample", 32'(n < 200), 32'd1);
        tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("T5 cs_n after rst", 32'(cs_n_m), 32'd1);
        check("T5 busy after rst", 32'(busy_m), 32'd0);
        check("T5 done after rst", 32'(done_m), 32'd0);
        check("T5 rx_data after rst", 32'(rx_m), 32'd0);
        tick();
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("T5 no done pulse", 32'(mon_dones), 32'd0);
        begin_xfer(1'b0, 8'h5A);
        finish_xfer("T5 restart", 8'h5A, 200, 1'b0, 8'h00);

        // T4: restart request at bit 3 is ignored
        set_mode(MODE0, 1'b1, 8'h00);
        begin_xfer(1'b0, 8'h00);
        n = 0;
        while (mon_smps < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("T4 reached bit 3", 32'(n < 200), 32'd1);
        tick();
        tx_data = 8'hFF;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        @(negedge clk);
        check("T4 still busy", 32'(busy_m), 32'd1);
        finish_xfer("T4", 8'h00, 200, 1'b0, 8'h00);
        repeat (40) @(negedge clk);
        check("T4 no second transfer", 32'(busy_m), 32'd0);

        // T3: LSB-first instance
        mon_sel = 1'b1;
        set_mode(MODE0, 1'b1, 8'h00);
        begin_xfer(1'b1, 8'h01);
        finish_xfer("T3 lsb", 8'h01, 200, 1'b0, 8'h00);
        mon_sel = 1'b0;

        // T6: slow divider, second word started the cycle after done
        div = 3;
        set_mode(MODE0, 1'b1, 8'h00);
        begin_xfer(1'b0, 8'h69);
        finish_xfer("T6 word1", 8'h69, 1000, 1'b1, 8'h96);
        @(negedge clk);
        check("T6 second start accepted", 32'(busy_m), 32'd1);
        finish_xfer("T6 word2", 8'h96, 1000, 1'b0, 8'h00);
        check("T6 cs_n gap", 32'(last_gap >= 1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
